// File: rtl/regfile_ctx_switch_ctrl.sv
// Context-switch sequencer: saves outgoing registers to memory, then
// reloads the incoming context through the register file spare port.
module regfile_ctx_switch_ctrl #(
  parameter int FIRST_REG  = 1,
  parameter int LAST_REG   = 31,
  parameter int WORD_BYTES = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        SWITCH_REQ,
  input  logic        RESTORE_ONLY,
  input  logic [31:0] SAVE_BASE,
  input  logic [31:0] RESTORE_BASE,
  output logic        BUSY,
  output logic        STALL,
  output logic        DONE,
  output logic [4:0]  RF_RADDR,
  input  logic [31:0] RF_RDATA,
  output logic [4:0]  RF_WADDR,
  output logic [31:0] RF_WDATA,
  output logic        RF_WRITE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  output logic        MEM_WRITE,
  output logic        MEM_READ,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_BUSYWAIT
);

  typedef enum logic [2:0] {
    IDLE,
    SAVE_RD,
    SAVE_WR,
    RST_RD,
    RST_WR,
    FINISH
  } state_t;

  localparam logic [4:0] FIRST = 5'(FIRST_REG);
  localparam logic [4:0] LAST  = 5'(LAST_REG);

  state_t      state;
  state_t      nxt;
  logic [4:0]  idx;
  logic [31:0] save_base;
  logic [31:0] rest_base;
  logic [31:0] data_q;
  logic        last;
  logic [31:0] offs;

  assign last = (idx == LAST);
  assign offs = 32'(idx) * 32'(WORD_BYTES);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (SWITCH_REQ) nxt = RESTORE_ONLY ? RST_RD : SAVE_RD;
      SAVE_RD: nxt = SAVE_WR;
      SAVE_WR: if (!MEM_BUSYWAIT) nxt = last ? RST_RD : SAVE_RD;
      RST_RD:  if (!MEM_BUSYWAIT) nxt = RST_WR;
      RST_WR:  nxt = last ? FINISH : RST_RD;
      FINISH:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Bases are latched once so software may reuse the inputs mid-switch.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      idx       <= FIRST;
      save_base <= '0;
      rest_base <= '0;
      data_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (SWITCH_REQ) begin
            idx       <= FIRST;
            save_base <= SAVE_BASE;
            rest_base <= RESTORE_BASE;
          end
        end
        SAVE_RD: data_q <= RF_RDATA;
        SAVE_WR: begin
          if (!MEM_BUSYWAIT) idx <= last ? FIRST : idx + 5'd1;
        end
        RST_RD: begin
          if (!MEM_BUSYWAIT) data_q <= MEM_RDATA;
        end
        RST_WR: begin
          if (!last) idx <= idx + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign BUSY  = (state != IDLE);
  assign STALL = (state != IDLE);

  always_comb begin
    DONE      = 1'b0;
    RF_RADDR  = '0;
    RF_WADDR  = '0;
    RF_WDATA  = '0;
    RF_WRITE  = 1'b0;
    MEM_ADDR  = '0;
    MEM_WDATA = '0;
    MEM_WRITE = 1'b0;
    MEM_READ  = 1'b0;
    unique case (state)
      SAVE_RD: RF_RADDR = idx;
      SAVE_WR: begin
        MEM_WRITE = 1'b1;
        MEM_ADDR  = save_base + offs;
        MEM_WDATA = data_q;
      end
      RST_RD: begin
        MEM_READ = 1'b1;
        MEM_ADDR = rest_base + offs;
      end
      RST_WR: begin
        RF_WRITE = 1'b1;
        RF_WADDR = idx;
        RF_WDATA = data_q;
      end
      FINISH:  DONE = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_ctx_switch_ctrl.sv
// Bench for regfile_ctx_switch_ctrl: register file and memory models
// plus a transaction-level expectation of every switch.
module tb_regfile_ctx_switch_ctrl;

  localparam int N = 31;

  logic        CLK = 0;
  logic        RESET = 1;
  logic        SWITCH_REQ = 0;
  logic        RESTORE_ONLY = 0;
  logic [31:0] SAVE_BASE = 0;
  logic [31:0] RESTORE_BASE = 0;
  logic        BUSY, STALL, DONE;
  logic [4:0]  RF_RADDR, RF_WADDR;
  logic [31:0] RF_RDATA = 0;
  logic [31:0] RF_WDATA;
  logic        RF_WRITE;
  logic [31:0] MEM_ADDR, MEM_WDATA;
  logic        MEM_WRITE, MEM_READ;
  logic [31:0] MEM_RDATA = 0;
  logic        MEM_BUSYWAIT = 0;

  regfile_ctx_switch_ctrl dut (
    .CLK(CLK), .RESET(RESET),
    .SWITCH_REQ(SWITCH_REQ), .RESTORE_ONLY(RESTORE_ONLY),
    .SAVE_BASE(SAVE_BASE), .RESTORE_BASE(RESTORE_BASE),
    .BUSY(BUSY), .STALL(STALL), .DONE(DONE),
    .RF_RADDR(RF_RADDR), .RF_RDATA(RF_RDATA),
    .RF_WADDR(RF_WADDR), .RF_WDATA(RF_WDATA), .RF_WRITE(RF_WRITE),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_WRITE(MEM_WRITE), .MEM_READ(MEM_READ),
    .MEM_RDATA(MEM_RDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  initial forever #5 CLK = ~CLK;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
  } op_t;

  int checks = 0;
  int failures = 0;
  logic [31:0] rf [32];
  logic [31:0] mem [int unsigned];
  op_t expq [$];
  bit  mbusy = 0;
  int  cyc = 0, stalls = 0, len = 0;
  int  tick = 0, acc_tick = 0, done_cnt = 0, last_lat = 0;
  int  mode = 0, waitn = 0, wcnt = 0;
  bit  prev_st = 0;
  logic [65:0] prev_bus = 0;

  task automatic chk(input string name, input logic [95:0] act,
                     input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dflt(logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] memrd(logic [31:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction

  function automatic op_t mk(int k, logic [31:0] a, logic [31:0] d);
    op_t o;
    o.kind = k;
    o.addr = a;
    o.data = d;
    return o;
  endfunction

  function automatic int pick();
    if (mode == 0) return 0;
    if (mode == 1) return 3;
    return int'($urandom_range(0, 2));
  endfunction

  // kind 0: memory write, 1: memory read, 2: register file write
  task automatic build(bit ro, logic [31:0] sb, logic [31:0] rb);
    logic [31:0] mc [int unsigned];
    logic [31:0] a, d;
    mc = mem;
    expq.delete();
    if (!ro) begin
      for (int i = 1; i <= N; i++) begin
        a = sb + 32'(4 * i);
        expq.push_back(mk(0, a, rf[i]));
        mc[a] = rf[i];
      end
    end
    for (int i = 1; i <= N; i++) begin
      a = rb + 32'(4 * i);
      d = mc.exists(a) ? mc[a] : dflt(a);
      expq.push_back(mk(1, a, 32'h0));
      expq.push_back(mk(2, 32'(i), d));
    end
    len = ro ? 2 * N + 1 : 4 * N + 1;
  endtask

  task automatic pop(int k, logic [31:0] a, logic [31:0] d);
    op_t o;
    if (expq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_op: got kind %0d addr %0h, required none",
               k, a);
    end else begin
      o = expq.pop_front();
      chk("op_kind", k, o.kind);
      chk("op_addr", a, o.addr);
      if (k != 1) chk("op_data", d, o.data);
    end
  endtask

  // Environment at the active edge: memory, register file, switch model.
  initial forever begin
    @(posedge CLK or posedge RESET);
    if (RESET) begin
      mbusy = 0;
      expq.delete();
      wcnt = 0;
    end else begin
      tick++;
      if (MEM_READ || MEM_WRITE) begin
        if (MEM_BUSYWAIT) wcnt++;
        else begin
          if (MEM_WRITE) mem[MEM_ADDR] = MEM_WDATA;
          wcnt = 0;
          waitn = pick();
        end
      end
      if (RF_WRITE) rf[RF_WADDR] = RF_WDATA;
      if (mbusy) begin
        cyc++;
        if (MEM_BUSYWAIT && (MEM_READ || MEM_WRITE)) stalls++;
        if (cyc == len + stalls) mbusy = 0;
      end else if (SWITCH_REQ) begin
        build(RESTORE_ONLY, SAVE_BASE, RESTORE_BASE);
        cyc = 0;
        stalls = 0;
        acc_tick = tick;
        mbusy = 1;
      end
    end
  end

  // Opposite edge: drive memory/regfile responses, then compare.
  initial forever begin
    @(negedge CLK);
    MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (wcnt < waitn);
    MEM_RDATA = MEM_READ ? memrd(MEM_ADDR) : 32'h0;
    RF_RDATA = rf[RF_RADDR];
    if (RESET) prev_st = 0;
    else begin
      if (!mbusy) begin
        chk("idle_outputs", |{BUSY, STALL, DONE, RF_RADDR, RF_WADDR,
            RF_WDATA, RF_WRITE, MEM_ADDR, MEM_WDATA, MEM_WRITE,
            MEM_READ}, 0);
      end else begin
        chk("busy_stall", {BUSY, STALL}, 2'b11);
        chk("done", DONE, cyc == len + stalls - 1);
        chk("rd_wr_excl", MEM_READ && MEM_WRITE, 0);
        chk("inactive_zero",
            (!RF_WRITE && (RF_WADDR != 0 || RF_WDATA != 0)) ||
            (!MEM_READ && !MEM_WRITE && MEM_ADDR != 0) ||
            (!MEM_WRITE && MEM_WDATA != 0), 0);
      end
      if (prev_st)
        chk("stall_stable",
            {MEM_ADDR, MEM_WDATA, MEM_READ, MEM_WRITE}, prev_bus);
      prev_st = (MEM_READ || MEM_WRITE) && MEM_BUSYWAIT;
      prev_bus = {MEM_ADDR, MEM_WDATA, MEM_READ, MEM_WRITE};
      if (MEM_WRITE && !MEM_BUSYWAIT) pop(0, MEM_ADDR, MEM_WDATA);
      if (MEM_READ && !MEM_BUSYWAIT) pop(1, MEM_ADDR, 32'h0);
      if (RF_WRITE) pop(2, {27'b0, RF_WADDR}, RF_WDATA);
      if (DONE) begin
        done_cnt++;
        last_lat = tick - acc_tick + 1;
        chk("queue_drained", expq.size(), 0);
      end
    end
  end

  task automatic wait_done(int d0, int bound);
    for (int k = 0; k < bound && done_cnt == d0; k++) begin
      @(negedge CLK);
      #1;
    end
    chk("done_seen", done_cnt - d0, 1);
  endtask

  task automatic run(bit ro, logic [31:0] sb, logic [31:0] rb,
                     int bound, bit harass);
    int d0;
    d0 = done_cnt;
    @(negedge CLK);
    #1;
    SWITCH_REQ = 1;
    RESTORE_ONLY = ro;
    SAVE_BASE = sb;
    RESTORE_BASE = rb;
    @(negedge CLK);
    #1;
    SWITCH_REQ = 0;
    RESTORE_ONLY = 1'($urandom_range(0, 1));
    SAVE_BASE = $urandom;
    RESTORE_BASE = $urandom;
    for (int k = 0; k < bound && done_cnt == d0; k++) begin
      if (harass) begin
        SWITCH_REQ = (k % 9 < 3);
        SAVE_BASE = $urandom;
        RESTORE_BASE = $urandom;
        RESTORE_ONLY = 1'($urandom_range(0, 1));
      end
      @(negedge CLK);
      #1;
    end
    SWITCH_REQ = 0;
    chk("done_seen", done_cnt - d0, 1);
  endtask

  initial begin
    int bad;
    int d0;
    bit found;
    logic [31:0] sb, rb;
    for (int i = 0; i < 32; i++) rf[i] = 0;
    #1;
    chk("reset_state", |{BUSY, STALL, DONE, RF_RADDR, RF_WADDR, RF_WDATA,
        RF_WRITE, MEM_ADDR, MEM_WDATA, MEM_WRITE, MEM_READ}, 0);
    repeat (3) @(negedge CLK);
    #2;
    RESET = 0;

    // full switch, zero-wait memory
    for (int i = 1; i <= N; i++) begin
      rf[i] = 32'h100 + 32'(i);
      mem[32'h2000 + 32'(4 * i)] = 32'hA00 + 32'(i);
    end
    run(0, 32'h1000, 32'h2000, 200, 0);
    chk("lat_full", last_lat, 125);
    bad = 0;
    for (int i = 1; i <= N; i++) begin
      if (memrd(32'h1000 + 32'(4 * i)) !== 32'h100 + 32'(i)) bad++;
      if (rf[i] !== 32'hA00 + 32'(i)) bad++;
    end
    chk("full_contents", bad, 0);

    // restore only
    for (int i = 1; i <= N; i++) mem[32'h2000 + 32'(4 * i)] = 32'hB00 + 32'(i);
    run(1, 32'h4000, 32'h2000, 200, 0);
    chk("lat_restore_only", last_lat, 63);
    chk("no_save_write", mem.exists(32'h4004), 0);
    bad = 0;
    for (int i = 1; i <= N; i++) if (rf[i] !== 32'hB00 + 32'(i)) bad++;
    chk("restore_contents", bad, 0);

    // three wait cycles on every access
    for (int i = 1; i <= N; i++) rf[i] = 32'h300 + 32'(i);
    mode = 1;
    waitn = 3;
    run(0, 32'h5000, 32'h2000, 600, 0);
    chk("lat_stalled", last_lat, 311);
    chk("stalled_save_lo", memrd(32'h5004), 32'h301);
    chk("stalled_save_hi", memrd(32'h507C), 32'h31F);
    mode = 0;
    waitn = 0;

    // requests and base changes while busy
    d0 = done_cnt;
    run(0, 32'h6000, 32'h2000, 400, 1);
    repeat (20) @(negedge CLK);
    #1;
    chk("single_done", done_cnt - d0, 1);
    chk("harass_save_lo", memrd(32'h6004), 32'hB01);
    chk("harass_save_hi", memrd(32'h607C), 32'hB1F);

    // reset while reading index 5 of the restore area
    @(negedge CLK);
    #1;
    SWITCH_REQ = 1;
    RESTORE_ONLY = 0;
    SAVE_BASE = 32'h7000;
    RESTORE_BASE = 32'h2000;
    @(negedge CLK);
    #1;
    SWITCH_REQ = 0;
    found = 0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(negedge CLK);
      #1;
      if (MEM_READ && MEM_ADDR == 32'h2014) found = 1;
    end
    chk("reset_point_reached", found, 1);
    #1;
    RESET = 1;
    #1;
    chk("reset_async_outputs", |{BUSY, STALL, DONE, RF_RADDR, RF_WADDR,
        RF_WDATA, RF_WRITE, MEM_ADDR, MEM_WDATA, MEM_WRITE, MEM_READ}, 0);
    @(negedge CLK);
    #2;
    RESET = 0;
    for (int i = 1; i <= N; i++) rf[i] = 32'h800 + 32'(i);
    run(0, 32'h8000, 32'h2000, 200, 0);
    chk("lat_after_reset", last_lat, 125);
    chk("restart_first", memrd(32'h8004), 32'h801);

    // back-to-back with the request held high
    d0 = done_cnt;
    @(negedge CLK);
    #1;
    SWITCH_REQ = 1;
    RESTORE_ONLY = 1;
    SAVE_BASE = 32'h9000;
    RESTORE_BASE = 32'h2000;
    wait_done(d0, 200);
    @(negedge CLK);
    #1;
    chk("b2b_gap", STALL, 0);
    @(negedge CLK);
    #1;
    chk("b2b_reaccept", STALL, 1);
    SWITCH_REQ = 0;
    wait_done(d0 + 1, 200);
    chk("lat_b2b", last_lat, 63);

    // randomized switches with random wait states
    mode = 2;
    for (int t = 0; t < 8; t++) begin
      for (int i = 1; i <= N; i++) rf[i] = $urandom;
      waitn = int'($urandom_range(0, 2));
      sb = $urandom & 32'hFFFF_FFFC;
      rb = $urandom & 32'hFFFF_FFFC;
      if (t == 0) sb = 32'hFFFF_FFF0;
      if (t == 1) rb = sb + 32'h40;
      run(1'($urandom_range(0, 1)), sb, rb, 1000, t[0]);
    end
    chk("rf_x0", rf[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
